// File: rtl/p0011_pkg.sv
// Shared types for the grid run-product solver: direction codes, FSM states and an
// elaboration-time clog2 used to size cell addresses.
package p0011_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT  = 2'd0,
    DIR_DOWN   = 2'd1,
    DIR_DRIGHT = 2'd2,
    DIR_DLEFT  = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StScan = 3'd1,
    StMul  = 3'd2,
    StCmp  = 3'd3,
    StFin  = 3'd4
  } state_e;

  // Never returns 0 so a 1x1 grid still gets a usable 1-bit address.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/grid_mem.sv
// N*N cell store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module grid_mem
  import p0011_pkg::*;
#(
  parameter int unsigned N      = 20,
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned AW     = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [ELEM_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [ELEM_W-1:0] rd_data
);

  localparam int unsigned Cells = N * N;

  logic [ELEM_W-1:0] mem [Cells];

  // Addresses past the last cell are dropped rather than aliased.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < Cells)) mem[wr_addr] <= wr_data;
  end

  assign rd_data = (32'(rd_addr) < Cells) ? mem[rd_addr] : '0;

endmodule

// File: rtl/grid_run_product_max.sv
// Scans every K-long run (right, down, down-right, down-left) of an NxN grid and
// keeps the largest product, its origin and direction; flags products wider than RES_W.
module grid_run_product_max
  import p0011_pkg::*;
#(
  parameter int unsigned  N      = 20,
  parameter int unsigned  K      = 4,
  parameter int unsigned  ELEM_W = 8,
  parameter int unsigned  RES_W  = 32,
  localparam int unsigned AW     = p0011_pkg::clog2(N * N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [ELEM_W-1:0] wr_data,
  output logic              busy,
  output logic [RES_W-1:0]  result,
  output logic [AW-1:0]     best_row,
  output logic [AW-1:0]     best_col,
  output logic [1:0]        best_dir,
  output logic              done,
  output logic              error
);

  state_e            state_q, state_d;
  logic [AW-1:0]     r_q, r_d, c_q, c_d, step_q, step_d;
  logic [1:0]        dir_q, dir_d;
  logic [RES_W-1:0]  prod_q, prod_d, result_q, result_d;
  logic [AW-1:0]     best_row_q, best_row_d, best_col_q, best_col_d;
  logic [1:0]        best_dir_q, best_dir_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;

  logic [AW-1:0]           rd_addr, rd_row, rd_col;
  logic [ELEM_W-1:0]       rd_data;
  logic [RES_W+ELEM_W-1:0] full_prod;
  logic [31:0]             rr, cc;
  logic                    win_ok, last_win, adv;

  grid_mem #(
    .N      (N),
    .ELEM_W (ELEM_W),
    .AW     (AW)
  ) u_grid_mem (
    .clk     (clk),
    .wr_en   (wr_en & ~busy_q),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign rr = 32'(r_q);
  assign cc = 32'(c_q);

  always_comb begin
    case (dir_q)
      DIR_RIGHT:  win_ok = (cc + K <= N);
      DIR_DOWN:   win_ok = (rr + K <= N);
      DIR_DRIGHT: win_ok = (cc + K <= N) && (rr + K <= N);
      default:    win_ok = (rr + K <= N) && (cc + 32'd1 >= K);
    endcase
  end

  assign last_win = (r_q == AW'(N - 1)) && (c_q == AW'(N - 1)) && (dir_q == DIR_DLEFT);

  // Modular AW-bit arithmetic is exact here: every address of a valid window is < N*N.
  always_comb begin
    rd_row = r_q;
    rd_col = c_q;
    case (dir_q)
      DIR_RIGHT:  rd_col = c_q + step_q;
      DIR_DOWN:   rd_row = r_q + step_q;
      DIR_DRIGHT: begin
        rd_row = r_q + step_q;
        rd_col = c_q + step_q;
      end
      default: begin
        rd_row = r_q + step_q;
        rd_col = c_q - step_q;
      end
    endcase
  end

  assign rd_addr   = rd_row * AW'(N) + rd_col;
  assign full_prod = (RES_W + ELEM_W)'(prod_q) * (RES_W + ELEM_W)'(rd_data);

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    c_d        = c_q;
    dir_d      = dir_q;
    step_d     = step_q;
    prod_d     = prod_q;
    result_d   = result_q;
    best_row_d = best_row_q;
    best_col_d = best_col_q;
    best_dir_d = best_dir_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    adv        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StScan;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          result_d   = '0;
          best_row_d = '0;
          best_col_d = '0;
          best_dir_d = DIR_RIGHT;
          r_d        = '0;
          c_d        = '0;
          dir_d      = DIR_RIGHT;
        end
      end
      StScan: begin
        if (win_ok) begin
          prod_d  = RES_W'(1);
          step_d  = '0;
          state_d = StMul;
        end else begin
          adv = 1'b1;
        end
      end
      StMul: begin
        if (|full_prod[RES_W +: ELEM_W]) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          prod_d = full_prod[RES_W-1:0];
          step_d = step_q + AW'(1);
          if (step_q == AW'(K - 1)) state_d = StCmp;
        end
      end
      StCmp: begin
        // Strict compare keeps the earliest window on ties.
        if (prod_q > result_q) begin
          result_d   = prod_q;
          best_row_d = r_q;
          best_col_d = c_q;
          best_dir_d = dir_q;
        end
        adv = 1'b1;
      end
      StFin: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (adv) begin
      if (last_win) begin
        state_d = StFin;
      end else begin
        state_d = StScan;
        dir_d   = dir_q + 2'd1;
        if (dir_q == DIR_DLEFT) begin
          if (c_q == AW'(N - 1)) begin
            c_d = '0;
            r_d = r_q + AW'(1);
          end else begin
            c_d = c_q + AW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      r_q        <= '0;
      c_q        <= '0;
      dir_q      <= DIR_RIGHT;
      step_q     <= '0;
      prod_q     <= '0;
      result_q   <= '0;
      best_row_q <= '0;
      best_col_q <= '0;
      best_dir_q <= DIR_RIGHT;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      c_q        <= c_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      prod_q     <= prod_d;
      result_q   <= result_d;
      best_row_q <= best_row_d;
      best_col_q <= best_col_d;
      best_dir_q <= best_dir_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign busy     = busy_q;
  assign result   = result_q;
  assign best_row = best_row_q;
  assign best_col = best_col_q;
  assign best_dir = best_dir_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_grid_run_product_max.sv
// Bench for grid_run_product_max: three instances (20x20/K4, 4x4/K2, 3x3/K3 with a
// 16-bit result) checked against a window-enumerating reference model.
module tb_grid_run_product_max;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] st, we;
  logic [8:0] wa;
  logic [7:0] wd;

  logic        busy_v [3];
  logic        done_v [3];
  logic        err_v  [3];
  logic [31:0] res_v  [3];
  logic [8:0]  row_v  [3];
  logic [8:0]  col_v  [3];
  logic [1:0]  dir_v  [3];

  logic [3:0]  s_row, s_col, o_row, o_col;
  logic [15:0] o_res;

  assign row_v[1] = {5'd0, s_row};
  assign col_v[1] = {5'd0, s_col};
  assign row_v[2] = {5'd0, o_row};
  assign col_v[2] = {5'd0, o_col};
  assign res_v[2] = {16'd0, o_res};

  grid_run_product_max u_big (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .wr_en(we[0]), .wr_addr(wa), .wr_data(wd),
    .busy(busy_v[0]), .result(res_v[0]), .best_row(row_v[0]), .best_col(col_v[0]),
    .best_dir(dir_v[0]), .done(done_v[0]), .error(err_v[0])
  );

  grid_run_product_max #(.N(4), .K(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .wr_en(we[1]), .wr_addr(wa[3:0]), .wr_data(wd),
    .busy(busy_v[1]), .result(res_v[1]), .best_row(s_row), .best_col(s_col),
    .best_dir(dir_v[1]), .done(done_v[1]), .error(err_v[1])
  );

  grid_run_product_max #(.N(3), .K(3), .RES_W(16)) u_ovf (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .wr_en(we[2]), .wr_addr(wa[3:0]), .wr_data(wd),
    .busy(busy_v[2]), .result(o_res), .best_row(o_row), .best_col(o_col),
    .best_dir(dir_v[2]), .done(done_v[2]), .error(err_v[2])
  );

  int total = 0;
  int bad   = 0;

  int     mg [400];
  longint m_res;
  int     m_row, m_col, m_dir, m_cyc;
  bit     m_err;

  int euler [400] = '{
     8, 2,22,97,38,15, 0,40, 0,75, 4, 5, 7,78,52,12,50,77,91, 8,
    49,49,99,40,17,81,18,57,60,87,17,40,98,43,69,48, 4,56,62, 0,
    81,49,31,73,55,79,14,29,93,71,40,67,53,88,30, 3,49,13,36,65,
    52,70,95,23, 4,60,11,42,69,24,68,56, 1,32,56,71,37, 2,36,91,
    22,31,16,71,51,67,63,89,41,92,36,54,22,40,40,28,66,33,13,80,
    24,47,32,60,99, 3,45, 2,44,75,33,53,78,36,84,20,35,17,12,50,
    32,98,81,28,64,23,67,10,26,38,40,67,59,54,70,66,18,38,64,70,
    67,26,20,68, 2,62,12,20,95,63,94,39,63, 8,40,91,66,49,94,21,
    24,55,58, 5,66,73,99,26,97,17,78,78,96,83,14,88,34,89,63,72,
    21,36,23, 9,75, 0,76,44,20,45,35,14, 0,61,33,97,34,31,33,95,
    78,17,53,28,22,75,31,67,15,94, 3,80, 4,62,16,14, 9,53,56,92,
    16,39, 5,42,96,35,31,47,55,58,88,24, 0,17,54,24,36,29,85,57,
    86,56, 0,48,35,71,89, 7, 5,44,44,37,44,60,21,58,51,54,17,58,
    19,80,81,68, 5,94,47,69,28,73,92,13,86,52,17,77, 4,89,55,40,
     4,52, 8,83,97,35,99,16, 7,97,57,32,16,26,26,79,33,27,98,66,
    88,36,68,87,57,62,20,72, 3,46,33,67,46,55,12,32,63,93,53,69,
     4,42,16,73,38,25,39,11,24,94,72,18, 8,46,29,32,40,62,76,36,
    20,69,36,41,72,30,23,88,34,62,99,69,82,67,59,85,74, 4,36,16,
    20,73,35,29,78,31,90, 1,74,31,49,71,48,86,81,16,23,57, 5,54,
     1,70,54,71,83,51,54,69,16,71,92,67,63,52, 1,89,19,67,48,48
  };

  // Enumerates every window by walking its cells; cycle cost = K+2 per in-grid
  // window, 1 per window that leaves the grid, plus one closing cycle.
  task automatic model(input int n, input int k, input int resw);
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    m_res = 0; m_row = 0; m_col = 0; m_dir = 0; m_err = 0; m_cyc = 1;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        for (int d = 0; d < 4; d++) begin
          bit inb;
          longint p;
          inb = 1;
          for (int i = 0; i < k; i++) begin
            if (r + i * dr[d] >= n || c + i * dc[d] < 0 || c + i * dc[d] >= n) inb = 0;
          end
          if (!inb) begin
            m_cyc++;
            continue;
          end
          m_cyc += k + 2;
          p = 1;
          for (int i = 0; i < k; i++) begin
            p = p * mg[(r + i * dr[d]) * n + c + i * dc[d]];
            if (p >= (64'd1 << resw)) begin
              m_err = 1;
              return;
            end
          end
          if (p > m_res) begin
            m_res = p; m_row = r; m_col = c; m_dir = d;
          end
        end
      end
    end
  endtask

  task automatic load(input int idx, input int n);
    for (int i = 0; i < n * n; i++) begin
      wa = 9'(i);
      wd = 8'(mg[i]);
      we[idx] = 1'b1;
      @(posedge clk); #1;
      we[idx] = 1'b0;
    end
  endtask

  task automatic run(input int idx, input int budget, output int cyc, output bit busy0);
    st[idx] = 1'b1;
    @(posedge clk); #1;
    st[idx] = 1'b0;
    busy0 = busy_v[idx];
    cyc = 0;
    while (!done_v[idx] && !err_v[idx] && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (!done_v[idx] && !err_v[idx]) begin
      bad++;
      $display("FAIL timeout[%0d]: done=0 error=0 after %0d cycles, want done or error", idx, cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || err_v[i] !== 1'b0 || res_v[i] !== 32'd0 ||
          row_v[i] !== 9'd0 || col_v[i] !== 9'd0 || dir_v[i] !== 2'd0) begin
        bad++;
        $display("FAIL reset[%0d]: busy=%b done=%b err=%b res=%0d row=%0d col=%0d dir=%0d want all 0",
                 i, busy_v[i], done_v[i], err_v[i], res_v[i], row_v[i], col_v[i], dir_v[i]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_euler();
    int cyc;
    bit b0;
    for (int i = 0; i < 400; i++) mg[i] = euler[i];
    load(0, 20);
    model(20, 4, 32);
    run(0, 20000, cyc, b0);
    total++;
    if (b0 !== 1'b1) begin
      bad++; $display("FAIL euler busy_after_start: got %b want 1", b0);
    end
    total++;
    if (done_v[0] !== 1'b1 || err_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
      bad++; $display("FAIL euler flags: done=%b err=%b busy=%b want 1 0 0",
                      done_v[0], err_v[0], busy_v[0]);
    end
    total++;
    if (res_v[0] !== 32'd70600674 || row_v[0] !== 9'd12 || col_v[0] !== 9'd6 || dir_v[0] !== 2'd3)
    begin
      bad++; $display("FAIL euler best: got %0d (%0d,%0d) d%0d want 70600674 (12,6) d3",
                      res_v[0], row_v[0], col_v[0], dir_v[0]);
    end
    total++;
    if (longint'(res_v[0]) !== m_res || cyc !== m_cyc) begin
      bad++; $display("FAIL euler model: res=%0d cyc=%0d want %0d cyc=%0d", res_v[0], cyc, m_res, m_cyc);
    end
  endtask

  task automatic test_small_seq();
    int cyc;
    bit b0;
    for (int i = 0; i < 16; i++) mg[i] = i + 1;
    load(1, 4);
    run(1, 2000, cyc, b0);
    total++;
    if (done_v[1] !== 1'b1 || err_v[1] !== 1'b0 || res_v[1] !== 32'd240 || row_v[1] !== 9'd3 ||
        col_v[1] !== 9'd2 || dir_v[1] !== 2'd0) begin
      bad++; $display("FAIL small_seq: done=%b err=%b res=%0d (%0d,%0d) d%0d want 1 0 240 (3,2) d0",
                      done_v[1], err_v[1], res_v[1], row_v[1], col_v[1], dir_v[1]);
    end
  endtask

  task automatic test_tie();
    int cyc;
    bit b0;
    for (int i = 0; i < 16; i++) mg[i] = 2;
    load(1, 4);
    run(1, 2000, cyc, b0);
    total++;
    if (done_v[1] !== 1'b1 || res_v[1] !== 32'd4 || row_v[1] !== 9'd0 || col_v[1] !== 9'd0 ||
        dir_v[1] !== 2'd0) begin
      bad++; $display("FAIL tie: done=%b res=%0d (%0d,%0d) d%0d want 1 4 (0,0) d0",
                      done_v[1], res_v[1], row_v[1], col_v[1], dir_v[1]);
    end
  endtask

  task automatic test_zero();
    int cyc;
    bit b0;
    for (int i = 0; i < 16; i++) mg[i] = 0;
    load(1, 4);
    model(4, 2, 32);
    run(1, 2000, cyc, b0);
    total++;
    if (done_v[1] !== 1'b1 || err_v[1] !== 1'b0 || res_v[1] !== 32'd0 || row_v[1] !== 9'd0 ||
        col_v[1] !== 9'd0 || dir_v[1] !== 2'd0) begin
      bad++; $display("FAIL zero: done=%b err=%b res=%0d (%0d,%0d) d%0d want 1 0 0 (0,0) d0",
                      done_v[1], err_v[1], res_v[1], row_v[1], col_v[1], dir_v[1]);
    end
    total++;
    if (cyc !== m_cyc) begin
      bad++; $display("FAIL zero latency: got %0d cycles want %0d", cyc, m_cyc);
    end
  endtask

  task automatic test_overflow();
    int cyc;
    bit b0;
    for (int i = 0; i < 9; i++) mg[i] = 255;
    load(2, 3);
    run(2, 2000, cyc, b0);
    total++;
    if (err_v[2] !== 1'b1 || done_v[2] !== 1'b0 || busy_v[2] !== 1'b0 || res_v[2] !== 32'd0) begin
      bad++; $display("FAIL overflow: err=%b done=%b busy=%b res=%0d want 1 0 0 0",
                      err_v[2], done_v[2], busy_v[2], res_v[2]);
    end
  endtask

  task automatic test_random_small();
    int cyc;
    bit b0;
    for (int it = 0; it < 20; it++) begin
      int hi;
      hi = (it % 2 == 0) ? 255 : 3;
      for (int i = 0; i < 16; i++) mg[i] = int'($urandom_range(0, hi));
      load(1, 4);
      model(4, 2, 32);
      run(1, 2000, cyc, b0);
      total++;
      if (done_v[1] !== 1'b1 || longint'(res_v[1]) !== m_res || int'(row_v[1]) !== m_row ||
          int'(col_v[1]) !== m_col || int'(dir_v[1]) !== m_dir || cyc !== m_cyc) begin
        bad++;
        $display("FAIL rand_small[%0d]: done=%b res=%0d (%0d,%0d) d%0d cyc=%0d want %0d (%0d,%0d) d%0d cyc=%0d",
                 it, done_v[1], res_v[1], row_v[1], col_v[1], dir_v[1], cyc,
                 m_res, m_row, m_col, m_dir, m_cyc);
      end
    end
  endtask

  task automatic test_random_ovf();
    int cyc;
    bit b0;
    for (int it = 0; it < 20; it++) begin
      int hi;
      hi = (it % 3 == 0) ? 255 : 40;
      for (int i = 0; i < 9; i++) mg[i] = int'($urandom_range(0, hi));
      if (it % 3 == 0) mg[it % 9] = 0;
      load(2, 3);
      model(3, 3, 16);
      run(2, 2000, cyc, b0);
      total++;
      if (err_v[2] !== m_err || done_v[2] !== !m_err || busy_v[2] !== 1'b0 ||
          longint'(res_v[2]) !== m_res || int'(row_v[2]) !== m_row || int'(col_v[2]) !== m_col ||
          int'(dir_v[2]) !== m_dir) begin
        bad++;
        $display("FAIL rand_ovf[%0d]: err=%b done=%b busy=%b res=%0d (%0d,%0d) d%0d want err=%b res=%0d (%0d,%0d) d%0d",
                 it, err_v[2], done_v[2], busy_v[2], res_v[2], row_v[2], col_v[2], dir_v[2],
                 m_err, m_res, m_row, m_col, m_dir);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    bit b0;
    for (int i = 0; i < 16; i++) mg[i] = i + 1;
    load(1, 4);
    model(4, 2, 32);
    st[1] = 1'b1;
    @(posedge clk); #1;
    st[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    wa = 9'd0;
    wd = 8'd255;
    we[1] = 1'b1;
    st[1] = 1'b1;
    @(posedge clk); #1;
    we[1] = 1'b0;
    st[1] = 1'b0;
    cyc = 6;
    while (!done_v[1] && !err_v[1] && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (done_v[1] !== 1'b1 || res_v[1] !== 32'd240 || cyc !== m_cyc) begin
      bad++; $display("FAIL busy_ignore: done=%b res=%0d cyc=%0d want 1 240 cyc=%0d",
                      done_v[1], res_v[1], cyc, m_cyc);
    end
    run(1, 2000, cyc, b0);
    total++;
    if (res_v[1] !== 32'd240 || row_v[1] !== 9'd3 || col_v[1] !== 9'd2) begin
      bad++; $display("FAIL grid_frozen: res=%0d (%0d,%0d) want 240 (3,2)", res_v[1], row_v[1], col_v[1]);
    end
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    bit b0;
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (3000) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || err_v[0] !== 1'b0 || res_v[0] !== 32'd0) begin
      bad++; $display("FAIL mid_reset: busy=%b done=%b err=%b res=%0d want 0 0 0 0",
                      busy_v[0], done_v[0], err_v[0], res_v[0]);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(0, 20000, cyc, b0);
    total++;
    if (done_v[0] !== 1'b1 || res_v[0] !== 32'd70600674 || row_v[0] !== 9'd12 ||
        col_v[0] !== 9'd6 || dir_v[0] !== 2'd3) begin
      bad++; $display("FAIL rerun: done=%b res=%0d (%0d,%0d) d%0d want 1 70600674 (12,6) d3",
                      done_v[0], res_v[0], row_v[0], col_v[0], dir_v[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    st = '0;
    we = '0;
    wa = '0;
    wd = '0;
    test_reset();
    test_euler();
    test_small_seq();
    test_tie();
    test_zero();
    test_overflow();
    test_random_small();
    test_random_ovf();
    test_busy_ignore();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
